// File: rtl/mul_seq.sv
// mul_seq: shift-add multiplier that borrows a shared ADD ALU one partial product per granted cycle
module mul_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  alu_req_o,
    input  logic                  alu_gnt_i,
    output logic [DATA_WIDTH-1:0] alu_op1_o,
    output logic [DATA_WIDTH-1:0] alu_op2_o,
    output logic [3:0]            alu_ctrl_o,
    input  logic [DATA_WIDTH-1:0] alu_out_i
);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [DATA_WIDTH-1:0] r_result;
    logic [CW-1:0]         r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_req;
    logic [DATA_WIDTH-1:0] w_acc_next;
    logic                  w_last;

    // ALU operands are only driven while the ALU is being requested
    assign alu_op1_o  = r_req ? r_acc : '0;
    assign alu_op2_o  = r_req ? r_mcand : '0;
    assign alu_ctrl_o = 4'b0000;
    assign alu_req_o  = r_req;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign result_o   = r_result;

    // Accumulator candidate and early-exit test once no multiplier bits remain
    always_comb begin
        w_acc_next = r_mplier[0] ? alu_out_i : r_acc;
        w_last     = ((r_mplier >> 1) == '0) || (r_cnt == LAST);
    end

    // Control FSM with datapath registers and registered status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_req    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start_i) begin
                    r_acc    <= '0;
                    r_mcand  <= op1_i;
                    r_mplier <= op2_i;
                    r_cnt    <= '0;
                    r_state  <= RUN;
                    r_busy   <= 1'b1;
                    r_req    <= 1'b1;
                end
                RUN: if (alu_gnt_i) begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state  <= DONE;
                        r_result <= w_acc_next;
                        r_req    <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end
endmodule
